// File: rtl/mcp23s17_spi_responder.sv
// ---------------------------------------------------------------------------
// mcp23s17_spi_responder
//
// SPI mode-0 target emulating the MCP23S17 register subset (BANK=0 map) used
// by the joystick expander link. Serves synchronised GPIO pin levels, holds
// the configuration registers and drives INTA/INTB.
//
// Optional feature macro: MCP23S17_RESP_IRQ_EN
//   defined   -> interrupt-on-change detection with INTF/INTCAP latching
//   undefined -> INTF/INTCAP read 00, GPINTEN is storage only, and
//                inta/intb sit at the inactive level (~INTPOL)
//
// Parameters
//   HW_ADDR      hardware address A2..A0, checked only while IOCON.HAEN=1
//   REG_TOP      last address of the sequential pointer (wraps to 00)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   spi_cs_n     chip select, active-low, asynchronous
//   spi_sck      SPI clock (mode 0), asynchronous
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first
//   spi_miso_oe  high while an addressed read is driving miso
//   gpa_in       port A pin levels, asynchronous
//   gpb_in       port B pin levels, asynchronous
//   inta, intb   interrupt outputs, active level = IOCON.INTPOL
//   iocon_o      current IOCON value
// ---------------------------------------------------------------------------
module mcp23s17_spi_responder #(
    parameter logic [2:0] HW_ADDR = 3'b000,
    parameter logic [7:0] REG_TOP = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] gpa_in,
    input  logic [7:0] gpb_in,
    output logic       inta,
    output logic       intb,
    output logic [7:0] iocon_o
);

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, IGNORE} state_t;

    state_t      state_q;
    logic        csMeta_q, csSync_q;
    logic        sckMeta_q, sckSync_q, sckPrev_q;
    logic        mosiMeta_q, mosiSync_q;
    logic [7:0]  gpaMeta_q, gpaSync_q, gpbMeta_q, gpbSync_q;

    logic [2:0]  bitCnt_q;
    logic [6:0]  shiftIn_q;
    logic [7:0]  shiftOut_q;
    logic        rdMode_q;
    logic [7:0]  ptr_q;
    logic        miso_q, oe_q, inta_q, intb_q;

    logic [7:0]  iodirA_q, iodirB_q, gpintenA_q, gpintenB_q;
    logic [7:0]  iocon_q, gppuA_q, gppuB_q;
    logic [7:0]  intfA_q, intfB_q, intcapA_q, intcapB_q;

    logic        sckRise, sckFall, byteDone, snapTake;
    logic [7:0]  rxByte_d, ptrStep_d, snapAddr_d, snapData_d;

    // The chip-select synchroniser keeps running through reset so that a
    // reset landing mid-transaction can see that the bus is still selected.
    always_ff @(posedge clk) begin
        csMeta_q <= spi_cs_n;
        csSync_q <= csMeta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sckMeta_q  <= 1'b0;
            sckSync_q  <= 1'b0;
            sckPrev_q  <= 1'b0;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
            gpaMeta_q  <= 8'h00;
            gpaSync_q  <= 8'h00;
            gpbMeta_q  <= 8'h00;
            gpbSync_q  <= 8'h00;
        end else begin
            sckMeta_q  <= spi_sck;
            sckSync_q  <= sckMeta_q;
            sckPrev_q  <= sckSync_q;
            mosiMeta_q <= spi_mosi;
            mosiSync_q <= mosiMeta_q;
            gpaMeta_q  <= gpa_in;
            gpaSync_q  <= gpaMeta_q;
            gpbMeta_q  <= gpb_in;
            gpbSync_q  <= gpbMeta_q;
        end
    end

    assign sckRise = sckSync_q & ~sckPrev_q;
    assign sckFall = ~sckSync_q & sckPrev_q;

    // A read snapshot is taken at the end of the address byte (from the
    // freshly received address) and at the end of every data byte (from the
    // pointer value that byte advances to).
    always_comb begin
        rxByte_d   = {shiftIn_q, mosiSync_q};
        byteDone   = sckRise && (bitCnt_q == 3'd7);
        ptrStep_d  = iocon_q[5] ? ptr_q
                   : ((ptr_q == REG_TOP) ? 8'h00 : ptr_q + 8'd1);
        snapAddr_d = (state_q == ADDR) ? rxByte_d : ptrStep_d;
        snapTake   = byteDone && !csSync_q && rdMode_q
                     && ((state_q == ADDR) || (state_q == DATA));
        case (snapAddr_d)
            8'h00:         snapData_d = iodirA_q;
            8'h01:         snapData_d = iodirB_q;
            8'h04:         snapData_d = gpintenA_q;
            8'h05:         snapData_d = gpintenB_q;
            8'h0A, 8'h0B:  snapData_d = {iocon_q[7:1], 1'b0};
            8'h0C:         snapData_d = gppuA_q;
            8'h0D:         snapData_d = gppuB_q;
            8'h0E:         snapData_d = intfA_q;
            8'h0F:         snapData_d = intfB_q;
            8'h10:         snapData_d = intcapA_q;
            8'h11:         snapData_d = intcapB_q;
            8'h12:         snapData_d = gpaSync_q;
            8'h13:         snapData_d = gpbSync_q;
            default:       snapData_d = 8'h00;
        endcase
    end

    // Transaction FSM plus the register file it writes. Deselecting the chip
    // drops back to IDLE from any state; a partially received byte is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= csSync_q ? IDLE : IGNORE;
            bitCnt_q   <= 3'd0;
            shiftIn_q  <= 7'd0;
            shiftOut_q <= 8'h00;
            rdMode_q   <= 1'b0;
            ptr_q      <= 8'h00;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            iodirA_q   <= 8'hFF;
            iodirB_q   <= 8'hFF;
            gpintenA_q <= 8'h00;
            gpintenB_q <= 8'h00;
            iocon_q    <= 8'h00;
            gppuA_q    <= 8'h00;
            gppuB_q    <= 8'h00;
        end else if (csSync_q) begin
            state_q  <= IDLE;
            bitCnt_q <= 3'd0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= OPCODE;
                    bitCnt_q <= 3'd0;
                end
                IGNORE: begin
                    state_q <= IGNORE;
                end
                default: begin
                    if (sckRise) begin
                        shiftIn_q <= rxByte_d[6:0];
                        bitCnt_q  <= bitCnt_q + 3'd1;
                    end
                    if (byteDone) begin
                        case (state_q)
                            OPCODE: begin
                                rdMode_q <= rxByte_d[0];
                                if ((rxByte_d[7:4] != 4'b0100)
                                    || (iocon_q[3] && (rxByte_d[3:1] != HW_ADDR)))
                                    state_q <= IGNORE;
                                else
                                    state_q <= ADDR;
                            end
                            ADDR: begin
                                ptr_q   <= rxByte_d;
                                state_q <= DATA;
                                if (rdMode_q) begin
                                    shiftOut_q <= snapData_d;
                                    oe_q       <= 1'b1;
                                end
                            end
                            DATA: begin
                                ptr_q <= ptrStep_d;
                                if (rdMode_q) begin
                                    shiftOut_q <= snapData_d;
                                end else begin
                                    case (ptr_q)
                                        8'h00:        iodirA_q   <= rxByte_d;
                                        8'h01:        iodirB_q   <= rxByte_d;
                                        8'h04:        gpintenA_q <= rxByte_d;
                                        8'h05:        gpintenB_q <= rxByte_d;
                                        8'h0A, 8'h0B: iocon_q    <= {rxByte_d[7:1], 1'b0};
                                        8'h0C:        gppuA_q    <= rxByte_d;
                                        8'h0D:        gppuB_q    <= rxByte_d;
                                        default:      ;
                                    endcase
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (sckFall && oe_q) begin
                        miso_q     <= shiftOut_q[7];
                        shiftOut_q <= {shiftOut_q[6:0], 1'b0};
                    end
                end
            endcase
        end
    end

`ifdef MCP23S17_RESP_IRQ_EN
    logic [7:0] gpaPrev_q, gpbPrev_q, qualA, qualB;
    logic       clrA, clrB;

    // Reading GPIOx or INTCAPx re-arms the port; a qualifying change seen in
    // the same clock takes priority over the clear.
    always_comb begin
        qualA = (gpaSync_q ^ gpaPrev_q) & gpintenA_q;
        qualB = (gpbSync_q ^ gpbPrev_q) & gpintenB_q;
        clrA  = snapTake && ((snapAddr_d == 8'h10) || (snapAddr_d == 8'h12));
        clrB  = snapTake && ((snapAddr_d == 8'h11) || (snapAddr_d == 8'h13));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpaPrev_q <= 8'h00;
            gpbPrev_q <= 8'h00;
            intfA_q   <= 8'h00;
            intfB_q   <= 8'h00;
            intcapA_q <= 8'h00;
            intcapB_q <= 8'h00;
        end else begin
            gpaPrev_q <= gpaSync_q;
            gpbPrev_q <= gpbSync_q;
            if ((qualA != 8'h00) && ((intfA_q == 8'h00) || clrA)) begin
                intfA_q   <= qualA;
                intcapA_q <= gpaSync_q;
            end else if (clrA) begin
                intfA_q <= 8'h00;
            end
            if ((qualB != 8'h00) && ((intfB_q == 8'h00) || clrB)) begin
                intfB_q   <= qualB;
                intcapB_q <= gpbSync_q;
            end else if (clrB) begin
                intfB_q <= 8'h00;
            end
        end
    end
`else
    assign intfA_q   = 8'h00;
    assign intfB_q   = 8'h00;
    assign intcapA_q = 8'h00;
    assign intcapB_q = 8'h00;
`endif

    // Interrupt pins: MIRROR ORs the two ports, INTPOL picks the active level.
    always_ff @(posedge clk) begin
        if (rst) begin
            inta_q <= 1'b1;
            intb_q <= 1'b1;
        end else begin
            if (iocon_q[6]) begin
                inta_q <= ~(iocon_q[1] ^ ((|intfA_q) | (|intfB_q)));
                intb_q <= ~(iocon_q[1] ^ ((|intfA_q) | (|intfB_q)));
            end else begin
                inta_q <= ~(iocon_q[1] ^ (|intfA_q));
                intb_q <= ~(iocon_q[1] ^ (|intfB_q));
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign inta        = inta_q;
    assign intb        = intb_q;
    assign iocon_o     = iocon_q;

endmodule

// File: tb/tb_mcp23s17_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_mcp23s17_spi_responder
//
// Drives SPI mode-0 transactions into mcp23s17_spi_responder and compares
// read data, interrupt pins and IOCON against a register-level model of the
// expander kept in this file. Follows MCP23S17_RESP_IRQ_EN like the design.
// ---------------------------------------------------------------------------
module tb_mcp23s17_spi_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n, spi_sck, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] gpa_in, gpb_in, iocon_o;
    logic       inta, intb;

    int nCompared   = 0;
    int nMismatched = 0;

    logic       oeSeen;
    logic       oeAfter, misoAfter;
    logic [7:0] txBuf [0:31];
    logic [7:0] rxBuf [0:31];

    // Register-level model of the expander
    logic [7:0] mIodir [0:1];
    logic [7:0] mGpinten [0:1];
    logic [7:0] mGppu [0:1];
    logic [7:0] mIntf [0:1];
    logic [7:0] mIntcap [0:1];
    logic [7:0] mPins [0:1];
    logic [7:0] mIocon;

    always #5 clk = ~clk;

    mcp23s17_spi_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .gpa_in      (gpa_in),
        .gpb_in      (gpb_in),
        .inta        (inta),
        .intb        (intb),
        .iocon_o     (iocon_o)
    );

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        rst      = 1'b1;
        clocks(4);
        rst = 1'b0;
        clocks(6);
    endtask

    // Shift nbits of tx (MSB first), capturing miso at each rising edge
    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            clocks(HALF);
            spi_sck = 1'b1;
            rx[i]   = spi_miso;
            oeSeen  = oeSeen | spi_miso_oe;
            clocks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic xferN(input int n);
        spi_cs_n = 1'b0;
        oeSeen   = 1'b0;
        clocks(HALF);
        for (int i = 0; i < n; i++) spiBits(txBuf[i], 8, rxBuf[i]);
        clocks(HALF);
        spi_cs_n  = 1'b1;
        clocks(3);
        oeAfter   = spi_miso_oe;
        misoAfter = spi_miso;
        clocks(7);
    endtask

    task automatic xfer3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        txBuf[0] = b0; txBuf[1] = b1; txBuf[2] = b2;
        xferN(3);
    endtask

    task automatic xfer4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
        txBuf[0] = b0; txBuf[1] = b1; txBuf[2] = b2; txBuf[3] = b3;
        xferN(4);
    endtask

    task automatic modelReset();
        mIodir[0] = 8'hFF; mIodir[1] = 8'hFF;
        for (int p = 0; p < 2; p++) begin
            mGpinten[p] = 8'h00; mGppu[p] = 8'h00;
            mIntf[p] = 8'h00; mIntcap[p] = 8'h00;
        end
        mIocon   = 8'h00;
        mPins[0] = gpa_in;
        mPins[1] = gpb_in;
    endtask

    function automatic logic [7:0] mRead(input logic [7:0] a);
        case (a)
            8'h00, 8'h01: return mIodir[a[0]];
            8'h04, 8'h05: return mGpinten[a[0]];
            8'h0A, 8'h0B: return mIocon & 8'hFE;
            8'h0C, 8'h0D: return mGppu[a[0]];
            8'h0E, 8'h0F: return mIntf[a[0]];
            8'h10, 8'h11: return mIntcap[a[0]];
            8'h12, 8'h13: return mPins[a[0]];
            default:      return 8'h00;
        endcase
    endfunction

    // A read snapshot re-arms the port when it covers GPIOx or INTCAPx
    task automatic mSnapshot(input logic [7:0] a, output logic [7:0] v);
        v = mRead(a);
        if (a == 8'h10 || a == 8'h12) mIntf[0] = 8'h00;
        if (a == 8'h11 || a == 8'h13) mIntf[1] = 8'h00;
    endtask

    task automatic mWrite(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'h00, 8'h01: mIodir[a[0]] = d;
            8'h04, 8'h05: mGpinten[a[0]] = d;
            8'h0A, 8'h0B: mIocon = d & 8'hFE;
            8'h0C, 8'h0D: mGppu[a[0]] = d;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] mNext(input logic [7:0] a);
        if (mIocon[5]) return a;
        return (a == 8'h15) ? 8'h00 : a + 8'd1;
    endfunction

    task automatic pinChange(input logic [7:0] newA, input logic [7:0] newB);
        logic [7:0] nv [0:1];
        nv[0] = newA; nv[1] = newB;
`ifdef MCP23S17_RESP_IRQ_EN
        for (int p = 0; p < 2; p++) begin
            logic [7:0] q;
            q = (nv[p] ^ mPins[p]) & mGpinten[p];
            if (q != 8'h00 && mIntf[p] == 8'h00) begin
                mIntf[p]   = q;
                mIntcap[p] = nv[p];
            end
        end
`endif
        mPins[0] = newA; mPins[1] = newB;
        gpa_in = newA; gpb_in = newB;
        clocks(8);
    endtask

    task automatic test_reset();
        doReset();
        modelReset();
        nCompared++;
        if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
            $display("[TB] FAIL reset_spi: miso=%b oe=%b want 0 0", spi_miso, spi_miso_oe);
            nMismatched++;
        end
        nCompared++;
        if (inta !== 1'b1 || intb !== 1'b1 || iocon_o !== 8'h00) begin
            $display("[TB] FAIL reset_irq: inta=%b intb=%b iocon=%h want 1 1 00", inta, intb, iocon_o);
            nMismatched++;
        end
        xfer4(8'h41, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'hFF || rxBuf[3] !== 8'hFF) begin
            $display("[TB] FAIL reset_iodir: got %h %h want FF FF", rxBuf[2], rxBuf[3]);
            nMismatched++;
        end
        nCompared++;
        if (oeSeen !== 1'b1 || oeAfter !== 1'b0 || misoAfter !== 1'b0) begin
            $display("[TB] FAIL read_oe: seen=%b after=%b miso_after=%b want 1 0 0",
                     oeSeen, oeAfter, misoAfter);
            nMismatched++;
        end
    endtask

    task automatic test_iocon_write();
        doReset();
        xfer3(8'h40, 8'h0A, 8'h52);
        nCompared++;
        if (iocon_o !== 8'h52) begin
            $display("[TB] FAIL iocon_o: got %h want 52", iocon_o);
            nMismatched++;
        end
        xfer3(8'h41, 8'h0B, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h52) begin
            $display("[TB] FAIL iocon_alias: got %h want 52", rxBuf[2]);
            nMismatched++;
        end
        nCompared++;
        if (inta !== 1'b0 || intb !== 1'b0) begin
            $display("[TB] FAIL intpol_idle: inta=%b intb=%b want 0 0", inta, intb);
            nMismatched++;
        end
    endtask

`ifdef MCP23S17_RESP_IRQ_EN
    task automatic test_irq();
        gpa_in = 8'hFF;
        gpb_in = 8'h00;
        doReset();
        xfer3(8'h40, 8'h0A, 8'h52);
        xfer3(8'h40, 8'h04, 8'hFF);
        nCompared++;
        if (inta !== 1'b0 || intb !== 1'b0) begin
            $display("[TB] FAIL irq_idle: inta=%b intb=%b want 0 0", inta, intb);
            nMismatched++;
        end
        gpa_in = 8'hFE;
        repeat (4) @(posedge clk);
        #1;
        nCompared++;
        if (inta !== 1'b1 || intb !== 1'b1) begin
            $display("[TB] FAIL irq_assert: inta=%b intb=%b want 1 1", inta, intb);
            nMismatched++;
        end
        @(negedge clk);
        xfer3(8'h41, 8'h10, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'hFE) begin
            $display("[TB] FAIL intcapa: got %h want FE", rxBuf[2]);
            nMismatched++;
        end
        nCompared++;
        if (inta !== 1'b0 || intb !== 1'b0) begin
            $display("[TB] FAIL irq_clear: inta=%b intb=%b want 0 0", inta, intb);
            nMismatched++;
        end
    endtask
`else
    task automatic test_irq_off();
        gpa_in = 8'hFF;
        gpb_in = 8'h00;
        doReset();
        xfer3(8'h40, 8'h04, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            gpa_in = ~gpa_in;
            clocks(8);
            nCompared++;
            if (inta !== 1'b1 || intb !== 1'b1) begin
                $display("[TB] FAIL irq_off: inta=%b intb=%b want 1 1", inta, intb);
                nMismatched++;
            end
        end
        xfer4(8'h41, 8'h0E, 8'h00, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h00 || rxBuf[3] !== 8'h00) begin
            $display("[TB] FAIL intf_off: got %h %h want 00 00", rxBuf[2], rxBuf[3]);
            nMismatched++;
        end
    endtask
`endif

    task automatic test_haen();
        doReset();
        xfer3(8'h40, 8'h0A, 8'h5A);
        xfer3(8'h42, 8'h0C, 8'h44);
        xfer3(8'h43, 8'h0C, 8'h00);
        nCompared++;
        if (oeSeen !== 1'b0) begin
            $display("[TB] FAIL haen_read_oe: got %b want 0", oeSeen);
            nMismatched++;
        end
        xfer3(8'h41, 8'h0C, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h00 || oeSeen !== 1'b1) begin
            $display("[TB] FAIL haen_write_drop: got %h oe=%b want 00 1", rxBuf[2], oeSeen);
            nMismatched++;
        end
        xfer3(8'h40, 8'h0A, 8'h52);
        xfer3(8'h42, 8'h0C, 8'h44);
        xfer3(8'h43, 8'h0C, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h44 || oeSeen !== 1'b1) begin
            $display("[TB] FAIL haen_off_accept: got %h oe=%b want 44 1", rxBuf[2], oeSeen);
            nMismatched++;
        end
    endtask

    task automatic test_pointer();
        logic [7:0] r;
        doReset();
        xfer4(8'h41, 8'h15, 8'h00, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h00 || rxBuf[3] !== 8'hFF) begin
            $display("[TB] FAIL wrap: got %h %h want 00 FF", rxBuf[2], rxBuf[3]);
            nMismatched++;
        end
        xfer3(8'h40, 8'h0A, 8'h20);
        r = 8'($urandom);
        gpa_in = r;
        clocks(6);
        xfer4(8'h41, 8'h12, 8'h00, 8'h00);
        nCompared++;
        if (rxBuf[2] !== r || rxBuf[3] !== r) begin
            $display("[TB] FAIL seqop_hold: got %h %h want %h %h", rxBuf[2], rxBuf[3], r, r);
            nMismatched++;
        end
    endtask

    task automatic test_partial_write();
        logic [7:0] junk;
        doReset();
        spi_cs_n = 1'b0;
        clocks(HALF);
        spiBits(8'h40, 8, junk);
        spiBits(8'h0C, 8, junk);
        spiBits(8'hA5, 4, junk);
        clocks(HALF);
        spi_cs_n = 1'b1;
        clocks(10);
        xfer3(8'h41, 8'h0C, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h00) begin
            $display("[TB] FAIL partial_write: got %h want 00", rxBuf[2]);
            nMismatched++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] junk;
        doReset();
        spi_cs_n = 1'b0;
        clocks(HALF);
        spiBits(8'h41, 8, junk);
        spiBits(8'h00, 8, junk);
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        clocks(2);
        oeSeen = 1'b0;
        spiBits(8'h00, 8, junk);
        spiBits(8'h40, 8, junk);
        spiBits(8'h0C, 8, junk);
        spiBits(8'h55, 8, junk);
        nCompared++;
        if (oeSeen !== 1'b0) begin
            $display("[TB] FAIL reset_mid_oe: got %b want 0", oeSeen);
            nMismatched++;
        end
        clocks(HALF);
        spi_cs_n = 1'b1;
        clocks(10);
        xfer3(8'h41, 8'h0C, 8'h00);
        nCompared++;
        if (rxBuf[2] !== 8'h00 || oeSeen !== 1'b1) begin
            $display("[TB] FAIL reset_mid_resume: got %h oe=%b want 00 1", rxBuf[2], oeSeen);
            nMismatched++;
        end
    endtask

    // Random register writes and pin activity, then a full sequential map read
    task automatic test_random();
        logic [7:0] addrs [0:9];
        logic [7:0] exp [0:21];
        logic [7:0] ptr, a, d, dummy;
        addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'h04; addrs[3] = 8'h05;
        addrs[4] = 8'h0C; addrs[5] = 8'h0D; addrs[6] = 8'h07; addrs[7] = 8'h14;
        addrs[8] = 8'h0E; addrs[9] = 8'h12;
        doReset();
        modelReset();
        for (int round = 0; round < 4; round++) begin
            pinChange(8'($urandom), 8'($urandom));
            for (int w = 0; w < 5; w++) begin
                a = addrs[$urandom_range(0, 9)];
                d = 8'($urandom);
                if (a == 8'h04 || a == 8'h05) d = $urandom_range(0, 1) != 0 ? 8'hFF : 8'h00;
                xfer3(8'h40, a, d);
                mWrite(a, d);
            end
            pinChange(8'($urandom), 8'($urandom));
            nCompared++;
            if (inta !== (mIntf[0] == 8'h00) || intb !== (mIntf[1] == 8'h00)) begin
                $display("[TB] FAIL rand_irq r%0d: inta=%b intb=%b intfA=%h intfB=%h",
                         round, inta, intb, mIntf[0], mIntf[1]);
                nMismatched++;
            end
            txBuf[0] = 8'h41;
            txBuf[1] = 8'h00;
            for (int k = 0; k < 22; k++) txBuf[2 + k] = 8'h00;
            ptr = 8'h00;
            for (int k = 0; k < 22; k++) begin
                mSnapshot(ptr, exp[k]);
                ptr = mNext(ptr);
            end
            mSnapshot(ptr, dummy);
            xferN(24);
            for (int k = 0; k < 22; k++) begin
                nCompared++;
                if (rxBuf[2 + k] !== exp[k]) begin
                    $display("[TB] FAIL rand_map r%0d reg %h: got %h want %h",
                             round, k, rxBuf[2 + k], exp[k]);
                    nMismatched++;
                end
            end
        end
    endtask

    initial begin
        gpa_in   = 8'h00;
        gpb_in   = 8'h00;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        rst      = 1'b1;
        clocks(4);
        test_reset();
        test_iocon_write();
`ifdef MCP23S17_RESP_IRQ_EN
        test_irq();
`else
        test_irq_off();
`endif
        test_haen();
        test_pointer();
        test_partial_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
